// File: rtl/fan_thermal_sequencer.sv
// Fan thermal sequencer: periodically turns a latched temperature code into a
// fan duty value and pushes it to a fan controller over AXI4-Lite, then
// optionally reads the tach register to detect a stalled fan.
// Optional feature macro: FAN_SEQ_TACH_CHECK_EN (tach read + stall detection).
module fan_thermal_sequencer #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          TICK_CYCLES = 100000,
    parameter logic [11:0] T_LOW       = 12'd1800,
    parameter logic [7:0]  DUTY_MIN    = 8'd64,
    parameter int          DUTY_SHIFT  = 2,
    parameter logic [31:0] TACH_MIN    = 32'd100,
    parameter int          STALL_LIMIT = 3
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        enable,
    input  logic        temp_valid,
    input  logic [11:0] temp_code,
    output logic [31:0] m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [31:0] m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    output logic [7:0]  duty_out,
    output logic        stall,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE, INIT_WR, INIT_B, WAIT_TICK, DUTY_WR, DUTY_B, TACH_AR, TACH_R
    } state_t;

    localparam logic [31:0] TICK_RELOAD = 32'(TICK_CYCLES - 1);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;

    state_t      state, state_nxt;
    logic [31:0] tick_cnt;
    logic [11:0] temp_lat;
    logic [12:0] temp_diff;
    logic [12:0] duty_sum;
    logic [7:0]  duty_calc;
    logic        wr_done;
    logic        go_init, go_duty, go_tach;

    // A write phase is finished once each channel has either already
    // handshaken or is handshaking this cycle.
    assign wr_done = (!m_axi_awvalid || m_axi_awready) &&
                     (!m_axi_wvalid  || m_axi_wready);

    assign m_axi_wstrb  = 4'hF;
    assign m_axi_bready = (state == INIT_B) || (state == DUTY_B);

    // Duty curve from the latched code: flat floor, linear ramp, clamp at 255.
    always_comb begin
        temp_diff = {1'b0, temp_lat} - {1'b0, T_LOW};
        duty_sum  = {5'd0, DUTY_MIN} + (temp_diff >> DUTY_SHIFT);
        if (temp_lat <= T_LOW)
            duty_calc = DUTY_MIN;
        else if (duty_sum > 13'd255)
            duty_calc = 8'hFF;
        else
            duty_calc = duty_sum[7:0];
    end

    // State register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic plus one-cycle launch strobes for each transaction.
    always_comb begin
        state_nxt = state;
        go_init   = 1'b0;
        go_duty   = 1'b0;
        go_tach   = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = INIT_WR;
                    go_init   = 1'b1;
                end
            end
            INIT_WR: if (wr_done) state_nxt = INIT_B;
            INIT_B: begin
                if (m_axi_bvalid) state_nxt = enable ? WAIT_TICK : IDLE;
            end
            WAIT_TICK: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (tick_cnt == 32'd0) begin
                    if (duty_calc != duty_out) begin
                        state_nxt = DUTY_WR;
                        go_duty   = 1'b1;
                    end else begin
`ifdef FAN_SEQ_TACH_CHECK_EN
                        state_nxt = TACH_AR;
                        go_tach   = 1'b1;
`else
                        state_nxt = WAIT_TICK;
`endif
                    end
                end
            end
            DUTY_WR: if (wr_done) state_nxt = DUTY_B;
            DUTY_B: begin
                if (m_axi_bvalid) begin
`ifdef FAN_SEQ_TACH_CHECK_EN
                    if (enable) begin
                        state_nxt = TACH_AR;
                        go_tach   = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
`else
                    state_nxt = enable ? WAIT_TICK : IDLE;
`endif
                end
            end
            TACH_AR: if (m_axi_arready) state_nxt = TACH_R;
            TACH_R: begin
                if (m_axi_rvalid) state_nxt = enable ? WAIT_TICK : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Tick counter: runs only while waiting, cleared while parked so a
    // fresh enable makes its first duty decision right after init.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)
            tick_cnt <= 32'd0;
        else if (state == IDLE)
            tick_cnt <= 32'd0;
        else if (state == WAIT_TICK && enable)
            tick_cnt <= (tick_cnt == 32'd0) ? TICK_RELOAD : tick_cnt - 32'd1;
    end

    // Temperature latch; a strobe coinciding with a decision lands after it.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)        temp_lat <= 12'd0;
        else if (temp_valid) temp_lat <= temp_code;
    end

    // Write address/data channels: both valids rise together, each drops
    // on its own handshake.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            m_axi_awaddr  <= 32'd0;
            m_axi_wdata   <= 32'd0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
        end else if (go_init) begin
            m_axi_awaddr  <= BASE_ADDR;
            m_axi_wdata   <= 32'd1;
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
        end else if (go_duty) begin
            m_axi_awaddr  <= BASE_ADDR + 32'h4;
            m_axi_wdata   <= {24'd0, duty_calc};
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
        end else begin
            if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
            if (m_axi_wvalid  && m_axi_wready)  m_axi_wvalid  <= 1'b0;
        end
    end

    // Committed duty and sticky error from write/read responses.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            duty_out <= 8'd0;
            err      <= 1'b0;
        end else begin
            if (m_axi_bvalid && m_axi_bready) begin
                if (m_axi_bresp != RESP_OKAY)
                    err <= 1'b1;
                else if (state == DUTY_B)
                    duty_out <= m_axi_wdata[7:0];
            end
            if (m_axi_rvalid && m_axi_rready && m_axi_rresp != RESP_OKAY)
                err <= 1'b1;
        end
    end

`ifdef FAN_SEQ_TACH_CHECK_EN
    localparam logic [7:0] STALL_MAX = 8'(STALL_LIMIT);

    logic [7:0] low_cnt;

    assign m_axi_rready = (state == TACH_R);

    // Read address channel for the tach register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            m_axi_araddr  <= 32'd0;
            m_axi_arvalid <= 1'b0;
        end else if (go_tach) begin
            m_axi_araddr  <= BASE_ADDR + 32'h8;
            m_axi_arvalid <= 1'b1;
        end else if (m_axi_arvalid && m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
        end
    end

    // Stall detection: consecutive low tach reads, cleared by a healthy one.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            low_cnt <= 8'd0;
            stall   <= 1'b0;
        end else if (m_axi_rvalid && m_axi_rready && m_axi_rresp == RESP_OKAY) begin
            if (m_axi_rdata < TACH_MIN) begin
                if (low_cnt != STALL_MAX)           low_cnt <= low_cnt + 8'd1;
                if (low_cnt + 8'd1 >= STALL_MAX)    stall   <= 1'b1;
            end else begin
                low_cnt <= 8'd0;
                stall   <= 1'b0;
            end
        end
    end
`else
    logic tach_unused;

    assign m_axi_araddr  = 32'd0;
    assign m_axi_arvalid = 1'b0;
    assign m_axi_rready  = 1'b0;
    assign stall         = 1'b0;
    assign tach_unused   = &{1'b0, go_tach, m_axi_rdata, m_axi_rresp,
                             TACH_MIN, 32'(STALL_LIMIT)};
`endif

endmodule

// File: tb/tb_fan_thermal_sequencer.sv
// Directed bench for fan_thermal_sequencer with a hand-driven AXI4-Lite slave.
// Tach/stall scenarios are compiled in when FAN_SEQ_TACH_CHECK_EN is defined.
module tb_fan_thermal_sequencer;

    localparam logic [31:0] BASE = 32'h4000_1000;
    localparam int          TICK = 8;

    logic        ACLK, ARESETN, enable, temp_valid;
    logic [11:0] temp_code;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [3:0]  m_axi_wstrb;
    logic [1:0]  m_axi_bresp, m_axi_rresp;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;
    logic [7:0]  duty_out;
    logic        stall, err;

    int checks = 0;
    int errors = 0;

    fan_thermal_sequencer #(.BASE_ADDR(BASE), .TICK_CYCLES(TICK)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .enable(enable),
        .temp_valid(temp_valid), .temp_code(temp_code),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata),
        .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready), .duty_out(duty_out), .stall(stall),
        .err(err)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    task automatic set_temp(input logic [11:0] code);
        temp_code  = code;
        temp_valid = 1'b1;
        @(negedge ACLK);
        temp_valid = 1'b0;
    endtask

    // Waits (bounded) for the next request: 1 = write, 2 = read, 0 = none.
    task automatic wait_req(output int kind);
        kind = 0;
        for (int i = 0; i < 200 && kind == 0; i++) begin
            if (m_axi_awvalid)      kind = 1;
            else if (m_axi_arvalid) kind = 2;
            else                    @(negedge ACLK);
        end
    endtask

    task automatic do_write(input string name, input int aw_dly, input int w_dly,
                            input logic [1:0] resp, input logic [31:0] exp_addr,
                            input logic [31:0] exp_data);
        int kind;
        int maxd;
        wait_req(kind);
        checks++;
        if (kind != 1) begin
            errors++;
            $display("FAIL %s_req: request kind %0d, expected 1 (write)", name, kind);
        end else begin
            checks++;
            if (m_axi_wvalid !== 1'b1) begin
                errors++; $display("FAIL %s_wvalid_with_aw: got %b expected 1", name, m_axi_wvalid);
            end
            checks++;
            if (m_axi_awaddr !== exp_addr) begin
                errors++; $display("FAIL %s_addr: got %h expected %h", name, m_axi_awaddr, exp_addr);
            end
            checks++;
            if (m_axi_wdata !== exp_data) begin
                errors++; $display("FAIL %s_data: got %h expected %h", name, m_axi_wdata, exp_data);
            end
            checks++;
            if (m_axi_wstrb !== 4'hF) begin
                errors++; $display("FAIL %s_wstrb: got %h expected f", name, m_axi_wstrb);
            end
            maxd = (aw_dly > w_dly) ? aw_dly : w_dly;
            for (int c = 0; c <= maxd; c++) begin
                checks++;
                if (m_axi_awvalid !== (c <= aw_dly) || m_axi_wvalid !== (c <= w_dly)) begin
                    errors++;
                    $display("FAIL %s_valid_hold c=%0d: aw/w got %b%b expected %b%b", name, c,
                             m_axi_awvalid, m_axi_wvalid, c <= aw_dly, c <= w_dly);
                end
                m_axi_awready = (c == aw_dly);
                m_axi_wready  = (c == w_dly);
                @(negedge ACLK);
            end
            m_axi_awready = 1'b0;
            m_axi_wready  = 1'b0;
            checks++;
            if (m_axi_awvalid !== 1'b0 || m_axi_wvalid !== 1'b0 || m_axi_bready !== 1'b1) begin
                errors++;
                $display("FAIL %s_bphase: aw/w/bready got %b%b%b expected 001", name,
                         m_axi_awvalid, m_axi_wvalid, m_axi_bready);
            end
            m_axi_bvalid = 1'b1;
            m_axi_bresp  = resp;
            @(negedge ACLK);
            m_axi_bvalid = 1'b0;
            m_axi_bresp  = 2'b00;
            checks++;
            if (m_axi_bready !== 1'b0) begin
                errors++; $display("FAIL %s_bready_drop: got %b expected 0", name, m_axi_bready);
            end
        end
    endtask

`ifdef FAN_SEQ_TACH_CHECK_EN
    task automatic do_read(input string name, input int ar_dly, input logic [31:0] val);
        int kind;
        wait_req(kind);
        checks++;
        if (kind != 2) begin
            errors++;
            $display("FAIL %s_req: request kind %0d, expected 2 (read)", name, kind);
        end else begin
            checks++;
            if (m_axi_araddr !== BASE + 32'h8) begin
                errors++; $display("FAIL %s_araddr: got %h expected %h", name, m_axi_araddr, BASE + 32'h8);
            end
            for (int c = 0; c <= ar_dly; c++) begin
                checks++;
                if (m_axi_arvalid !== 1'b1) begin
                    errors++; $display("FAIL %s_arvalid_hold: got %b expected 1", name, m_axi_arvalid);
                end
                m_axi_arready = (c == ar_dly);
                @(negedge ACLK);
            end
            m_axi_arready = 1'b0;
            checks++;
            if (m_axi_arvalid !== 1'b0 || m_axi_rready !== 1'b1) begin
                errors++;
                $display("FAIL %s_rphase: arvalid/rready got %b%b expected 01", name, m_axi_arvalid, m_axi_rready);
            end
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = val;
            @(negedge ACLK);
            m_axi_rvalid = 1'b0;
            m_axi_rdata  = 32'd0;
        end
    endtask
`endif

    // After each duty write the tach build also reads the tach register.
    task automatic tach_after(input string name);
`ifdef FAN_SEQ_TACH_CHECK_EN
        do_read(name, 0, 32'd500);
`else
        checks++;
        if (m_axi_arvalid !== 1'b0) begin
            errors++; $display("FAIL %s_no_read: arvalid got %b expected 0", name, m_axi_arvalid);
        end
`endif
    endtask

    task automatic expect_quiet(input string name, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            if (m_axi_awvalid || m_axi_arvalid) seen++;
            @(negedge ACLK);
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL %s: %0d cycles with a request, expected 0", name, seen);
        end
    endtask

    // A tick with unchanged duty: no write; tach read only when compiled in.
    task automatic test_no_change(input string name, input logic [7:0] exp_duty);
`ifdef FAN_SEQ_TACH_CHECK_EN
        do_read(name, 1, 32'd500);
`else
        expect_quiet(name, 2 * TICK + 4);
`endif
        checks++;
        if (duty_out !== exp_duty) begin
            errors++; $display("FAIL %s_duty: got %h expected %h", name, duty_out, exp_duty);
        end
    endtask

    task automatic check_duty(input string name, input logic [7:0] exp_duty, input logic exp_err);
        checks++;
        if (duty_out !== exp_duty || err !== exp_err) begin
            errors++;
            $display("FAIL %s: duty/err got %h/%b expected %h/%b", name, duty_out, err, exp_duty, exp_err);
        end
    endtask

    task automatic test_reset;
        ARESETN = 1'b0; enable = 1'b0; temp_valid = 1'b0; temp_code = 12'd0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bresp = 2'b00; m_axi_bvalid = 1'b0;
        m_axi_arready = 1'b0; m_axi_rdata = 32'd0; m_axi_rresp = 2'b00; m_axi_rvalid = 1'b0;
        repeat (3) @(negedge ACLK);
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready} !== 5'b0) begin
            errors++; $display("FAIL reset_handshake: got %b expected 00000",
                {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready});
        end
        checks++;
        if (m_axi_awaddr !== 32'd0 || m_axi_wdata !== 32'd0 || m_axi_araddr !== 32'd0) begin
            errors++; $display("FAIL reset_addr_data: got %h %h %h expected 0",
                m_axi_awaddr, m_axi_wdata, m_axi_araddr);
        end
        checks++;
        if (duty_out !== 8'd0 || stall !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL reset_status: duty/stall/err got %h/%b/%b expected 00/0/0",
                duty_out, stall, err);
        end
        ARESETN = 1'b1;
        expect_quiet("idle_disabled", 6);
    endtask

    task automatic test_init;
        set_temp(12'd1800);
        enable = 1'b1;
        do_write("init", 0, 0, 2'b00, BASE, 32'h1);
        check_duty("init_no_duty", 8'h00, 1'b0);
    endtask

    task automatic test_duty_ramp;
        do_write("duty_min", 0, 0, 2'b00, BASE + 32'h4, 32'h40);
        check_duty("duty_min_out", 8'h40, 1'b0);
        tach_after("duty_min_tach");
        set_temp(12'd2200);
        do_write("duty_2200", 1, 2, 2'b00, BASE + 32'h4, 32'hA4);
        check_duty("duty_2200_out", 8'hA4, 1'b0);
        tach_after("duty_2200_tach");
    endtask

    task automatic test_saturate;
        set_temp(12'd4095);
        do_write("duty_sat", 0, 0, 2'b00, BASE + 32'h4, 32'hFF);
        check_duty("duty_sat_out", 8'hFF, 1'b0);
        tach_after("duty_sat_tach");
        test_no_change("sat_same", 8'hFF);
    endtask

    task automatic test_split_handshake;
        set_temp(12'd2000);
        do_write("split", 0, 5, 2'b00, BASE + 32'h4, 32'h72);
        check_duty("split_out", 8'h72, 1'b0);
        tach_after("split_tach");
        test_no_change("split_once", 8'h72);
    endtask

    task automatic test_slverr;
        set_temp(12'd2200);
        do_write("slverr", 3, 1, 2'b10, BASE + 32'h4, 32'hA4);
        check_duty("slverr_keep", 8'h72, 1'b1);
        tach_after("slverr_tach");
        do_write("retry", 0, 0, 2'b00, BASE + 32'h4, 32'hA4);
        check_duty("retry_out", 8'hA4, 1'b1);
        tach_after("retry_tach");
    endtask

    task automatic test_stall;
`ifdef FAN_SEQ_TACH_CHECK_EN
        logic [3:0] exp_stall;
        logic [31:0] tach_vals [4];
        exp_stall = 4'b0100;
        tach_vals = '{32'd50, 32'd50, 32'd50, 32'd500};
        for (int i = 0; i < 4; i++) begin
            do_read("stall_rd", 0, tach_vals[i]);
            checks++;
            if (stall !== (i == 2)) begin
                errors++; $display("FAIL stall_step%0d: got %b expected %b", i, stall, exp_stall[i]);
            end
        end
`else
        checks++;
        if (stall !== 1'b0 || m_axi_arvalid !== 1'b0) begin
            errors++; $display("FAIL stall_tied: stall/arvalid got %b/%b expected 0/0", stall, m_axi_arvalid);
        end
`endif
    endtask

    task automatic test_disable_and_reset;
        int kind;
        set_temp(12'd1800);
        wait_req(kind);
        enable = 1'b0;
        do_write("dis_inflight", 0, 2, 2'b00, BASE + 32'h4, 32'h40);
        check_duty("dis_out", 8'h40, 1'b1);
        expect_quiet("dis_parked", 3 * TICK);
        set_temp(12'd4095);
        enable = 1'b1;
        do_write("reinit", 0, 0, 2'b00, BASE, 32'h1);
        wait_req(kind);
        checks++;
        if (kind != 1) begin
            errors++; $display("FAIL reinit_duty_req: kind %0d expected 1", kind);
        end
        ARESETN = 1'b0;
        #1;
        checks++;
        if (m_axi_awvalid !== 1'b0 || m_axi_wvalid !== 1'b0 || duty_out !== 8'd0 || err !== 1'b0) begin
            errors++; $display("FAIL reset_mid: aw/w/duty/err got %b%b/%h/%b expected 00/00/0",
                m_axi_awvalid, m_axi_wvalid, duty_out, err);
        end
        enable = 1'b0;
        @(negedge ACLK);
        @(negedge ACLK);
        ARESETN = 1'b1;
        expect_quiet("reset_mid_idle", 6);
    endtask

    initial begin
        test_reset();
        test_init();
        test_duty_ramp();
        test_saturate();
        test_split_handshake();
        test_slverr();
        test_stall();
        test_disable_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
